// File: rtl/piccolo_core_if.sv
// piccolo_core_if: handshake bundle between a plaintext/key producer, the
// Piccolo core and a ciphertext consumer.
//   in_valid / in_ready   : plaintext+key offer, accepted when both high
//   key                   : KEY_BITS cipher key, k0 in the top 16 bits
//   plaintext             : 64-bit block, X0 in the top 16 bits
//   out_valid / out_ready : ciphertext offer, retired when both high
//   ciphertext            : 64-bit result, X0 in the top 16 bits
// master = producer/consumer side, slave = the core.
interface piccolo_core_if #(
  parameter int KEY_BITS = 80
);
  logic                in_valid;
  logic                in_ready;
  logic [KEY_BITS-1:0] key;
  logic [63:0]         plaintext;
  logic                out_valid;
  logic                out_ready;
  logic [63:0]         ciphertext;

  modport master (
    output in_valid, key, plaintext, out_ready,
    input  in_ready, out_valid, ciphertext
  );

  modport slave (
    input  in_valid, key, plaintext, out_ready,
    output in_ready, out_valid, ciphertext
  );
endinterface

// File: rtl/piccolo_core.sv
// piccolo_core: iterative Piccolo-80 / Piccolo-128 encryption core.
// UNROLL rounds are evaluated per clock by a chain of round lanes; each lane
// derives its own round index, constant and key words from rc + lane offset.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : piccolo_core_if slave (in_valid/in_ready/key/plaintext,
//           out_valid/out_ready/ciphertext)
// Latency from the accept cycle to the first out_valid cycle is N+1 where
// N = ceil(R/UNROLL); ciphertext is held until out_ready.
module piccolo_core #(
  parameter int KEY_BITS = 80,
  parameter int UNROLL   = 1
) (
  input logic           clk,
  input logic           reset,
  piccolo_core_if.slave bus
);
  localparam int R   = (KEY_BITS == 128) ? 31 : 25;
  localparam int RCW = 8;
  localparam logic [RCW-1:0] R_L = RCW'(R);
  localparam logic [31:0] CON_XOR = (KEY_BITS == 128) ? 32'h6547a98b : 32'h0f1e2d3c;
  // lsb positions of k4 and of the word paired with it in output whitening
  // (k3 for 80-bit, k7 for 128-bit)
  localparam int K4_LSB = KEY_BITS - 80;
  localparam int KX_LSB = (KEY_BITS == 128) ? 0 : 16;

  if (!(KEY_BITS == 80 || KEY_BITS == 128)) begin : g_bad_key_bits
    $error("piccolo_core: KEY_BITS must be 80 or 128");
  end
  if (UNROLL < 1 || UNROLL > R) begin : g_bad_unroll
    $error("piccolo_core: UNROLL must be in 1..R");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [63:0]         x_reg;
  logic [63:0]         ct_reg;
  logic [RCW-1:0]      rc_reg;
  logic [KEY_BITS-1:0] kw_reg;
  logic [31:0]         wk_out_reg;
  logic                last;

  function automatic logic [3:0] sbox(input logic [3:0] a);
    logic [3:0] s;
    case (a)
      4'h0: s = 4'he; 4'h1: s = 4'h4; 4'h2: s = 4'hb; 4'h3: s = 4'h2;
      4'h4: s = 4'h3; 4'h5: s = 4'h8; 4'h6: s = 4'h0; 4'h7: s = 4'h9;
      4'h8: s = 4'h1; 4'h9: s = 4'ha; 4'ha: s = 4'h7; 4'hb: s = 4'hf;
      4'hc: s = 4'h6; 4'hd: s = 4'hc; 4'he: s = 4'h5; default: s = 4'hd;
    endcase
    return s;
  endfunction

  // multiply by x in GF(2^4) / x^4+x+1
  function automatic logic [3:0] gmul2(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
  endfunction

  function automatic logic [15:0] f_func(input logic [15:0] x);
    logic [3:0] s0, s1, s2, s3, m0, m1, m2, m3;
    s0 = sbox(x[15:12]);
    s1 = sbox(x[11:8]);
    s2 = sbox(x[7:4]);
    s3 = sbox(x[3:0]);
    m0 = gmul2(s0) ^ gmul2(s1) ^ s1 ^ s2 ^ s3;
    m1 = s0 ^ gmul2(s1) ^ gmul2(s2) ^ s2 ^ s3;
    m2 = s0 ^ s1 ^ gmul2(s2) ^ gmul2(s3) ^ s3;
    m3 = gmul2(s0) ^ s0 ^ s1 ^ s2 ^ gmul2(s3);
    return {sbox(m0), sbox(m1), sbox(m2), sbox(m3)};
  endfunction

  // (b0..b7) -> (b2,b7,b4,b1,b6,b3,b0,b5), b0 = most significant byte
  function automatic logic [63:0] rp(input logic [63:0] x);
    return {x[47:40], x[7:0], x[31:24], x[55:48],
            x[15:8], x[39:32], x[63:56], x[23:16]};
  endfunction

  // lane chain: element 0 is the registered state, element UNROLL the result
  logic [63:0]         lane_x [UNROLL+1];
  logic [KEY_BITS-1:0] lane_k [UNROLL+1];

  assign lane_x[0] = x_reg;
  assign lane_k[0] = kw_reg;

  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_lane
    logic [RCW-1:0] ridx;
    logic [4:0]     cidx;
    logic [31:0]    con;
    logic [31:0]    rk;
    logic [15:0]    x0, x1, x2, x3, y1, y3;
    logic [63:0]    mixed;

    assign ridx = rc_reg + RCW'(gi);
    assign cidx = 5'(ridx + 8'd1);
    assign con  = {cidx, 5'b00000, cidx, 2'b00, cidx, 5'b00000, cidx} ^ CON_XOR;

    if (KEY_BITS == 80) begin : g_k80
      logic [2:0] m5;
      assign m5 = 3'(ridx % 8'd5);
      always_comb begin
        rk = con ^ {lane_k[gi][47:32], lane_k[gi][31:16]};
        case (m5)
          3'd1, 3'd4: rk = con ^ {lane_k[gi][79:64], lane_k[gi][63:48]};
          3'd3:       rk = con ^ {lane_k[gi][15:0], lane_k[gi][15:0]};
          default:    ;
        endcase
      end
      assign lane_k[gi+1] = lane_k[gi];
    end else begin : g_k128
      // the word permutation lands just before every round i with i mod 4 == 3
      logic          perm_en;
      logic [127:0]  kperm;
      logic [15:0]   kw [8];
      logic [2:0]    sel_a;
      assign perm_en = (ridx[1:0] == 2'd3) && (ridx < R_L);
      assign kperm   = perm_en ?
        {lane_k[gi][95:80], lane_k[gi][111:96], lane_k[gi][31:16], lane_k[gi][15:0],
         lane_k[gi][127:112], lane_k[gi][79:64], lane_k[gi][63:48], lane_k[gi][47:32]} :
        lane_k[gi];
      always_comb begin
        for (int w = 0; w < 8; w++) begin
          kw[w] = kperm[127-16*w -: 16];
        end
      end
      // rk_2i uses k_((2i+2) mod 8), rk_2i+1 the following word
      assign sel_a = {ridx[1:0] + 2'd1, 1'b0};
      assign rk    = con ^ {kw[sel_a], kw[{sel_a[2:1], 1'b1}]};
      assign lane_k[gi+1] = kperm;
    end

    assign x0    = lane_x[gi][63:48];
    assign x1    = lane_x[gi][47:32];
    assign x2    = lane_x[gi][31:16];
    assign x3    = lane_x[gi][15:0];
    assign y1    = x1 ^ f_func(x0) ^ rk[31:16];
    assign y3    = x3 ^ f_func(x2) ^ rk[15:0];
    assign mixed = {x0, y1, x2, y3};
    // lanes past the final round pass the state through untouched
    assign lane_x[gi+1] = (ridx >= R_L)        ? lane_x[gi] :
                          (ridx == R_L - 8'd1) ? mixed      : rp(mixed);
  end

  assign last = (rc_reg + RCW'(UNROLL)) >= R_L;

  // input whitening keys from the live key bus, output ones captured alongside
  logic [15:0] k0_in, k1_in, k4_in, kx_in;
  assign k0_in = bus.key[KEY_BITS-1 -: 16];
  assign k1_in = bus.key[KEY_BITS-17 -: 16];
  assign k4_in = bus.key[K4_LSB +: 16];
  assign kx_in = bus.key[KX_LSB +: 16];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg      <= '0;
      ct_reg     <= '0;
      rc_reg     <= '0;
      kw_reg     <= '0;
      wk_out_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            x_reg <= bus.plaintext ^ {k0_in[15:8], k1_in[7:0], 16'h0000,
                                      k1_in[15:8], k0_in[7:0], 16'h0000};
            kw_reg     <= bus.key;
            rc_reg     <= '0;
            wk_out_reg <= {k4_in[15:8], kx_in[7:0], kx_in[15:8], k4_in[7:0]};
          end
        end
        RUN: begin
          x_reg  <= lane_x[UNROLL];
          kw_reg <= lane_k[UNROLL];
          rc_reg <= rc_reg + RCW'(UNROLL);
          if (last) begin
            ct_reg <= lane_x[UNROLL] ^ {wk_out_reg[31:16], 16'h0000,
                                        wk_out_reg[15:0], 16'h0000};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = (state_reg == IDLE);
  assign bus.out_valid  = (state_reg == DONE);
  assign bus.ciphertext = ct_reg;
endmodule
